// File: rtl/dg0045_ram_arbiter.sv
// rtl/dg0045_ram_arbiter.sv - single-port 32x4 RAM arbiter for CPU, debug port and display scanner
// One RAM access per clk_in; fixed CPU > debug > scanner priority with a scanner starvation guard.
module dg0045_ram_arbiter #(
  parameter logic [4:0] SCAN_BASE   = 5'd0,
  parameter int         DIGITS      = 8,
  parameter int         SCAN_PERIOD = 64,
  parameter int         MAX_WAIT    = 16
) (
  input  logic       clk_in,
  input  logic       RESET,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [3:0] cpu_wdata,
  output logic [3:0] cpu_rdata,
  output logic       cpu_ack,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [4:0] dbg_addr,
  input  logic [3:0] dbg_wdata,
  output logic [3:0] dbg_rdata,
  output logic       dbg_ack,
  input  logic       scan_en,
  output logic [3:0] seg_data,
  output logic [4:0] seg_digit,
  output logic       seg_valid,
  output logic       scan_miss,
  output logic [4:0] ram_addr,
  output logic [3:0] ram_din,
  output logic       ram_we,
  input  logic [3:0] ram_dout
);

  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_MAX    = WW'(MAX_WAIT);
  localparam logic [4:0]    IDX_LAST    = 5'(DIGITS - 1);

  logic [3:0]    r_cpu_rdata;
  logic          r_cpu_ack;
  logic [3:0]    r_dbg_rdata;
  logic          r_dbg_ack;
  logic [3:0]    r_seg_data;
  logic [4:0]    r_seg_digit;
  logic          r_seg_valid;
  logic          r_scan_miss;
  logic          r_scan_pend;
  logic [PW-1:0] r_period_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [4:0]    r_scan_idx;
  logic [4:0]    r_last_addr;
  logic [3:0]    r_last_din;

  logic       w_cpu_elig;
  logic       w_dbg_elig;
  logic       w_scan_top;
  logic       w_gnt_cpu;
  logic       w_gnt_dbg;
  logic       w_gnt_scan;
  logic       w_any_gnt;
  logic       w_wrap;
  logic [4:0] w_scan_addr;
  logic [4:0] w_sel_addr;
  logic [3:0] w_sel_din;
  logic       w_sel_we;

  // A port whose ack is high this cycle is not eligible, so a held req
  // becomes a fresh request only from the following cycle.
  assign w_cpu_elig  = cpu_req & ~r_cpu_ack;
  assign w_dbg_elig  = dbg_req & ~r_dbg_ack;
  assign w_scan_top  = r_scan_pend && (r_wait_cnt >= WAIT_MAX);
  assign w_scan_addr = SCAN_BASE + r_scan_idx;
  assign w_wrap      = scan_en && (r_period_cnt == PERIOD_LAST);
  assign w_any_gnt   = w_gnt_cpu | w_gnt_dbg | w_gnt_scan;

  always_comb begin
    w_gnt_cpu  = 1'b0;
    w_gnt_dbg  = 1'b0;
    w_gnt_scan = 1'b0;
    if (RESET) begin
      if (w_scan_top) begin
        w_gnt_scan = 1'b1;
      end else if (w_cpu_elig) begin
        w_gnt_cpu = 1'b1;
      end else if (w_dbg_elig) begin
        w_gnt_dbg = 1'b1;
      end else if (r_scan_pend) begin
        w_gnt_scan = 1'b1;
      end
    end
  end

  // With no winner the address/data lines hold their last driven values.
  always_comb begin
    w_sel_addr = r_last_addr;
    w_sel_din  = r_last_din;
    w_sel_we   = 1'b0;
    if (w_gnt_cpu) begin
      w_sel_addr = cpu_addr;
      w_sel_din  = cpu_wdata;
      w_sel_we   = cpu_we;
    end else if (w_gnt_dbg) begin
      w_sel_addr = dbg_addr;
      w_sel_din  = dbg_wdata;
      w_sel_we   = dbg_we;
    end else if (w_gnt_scan) begin
      w_sel_addr = w_scan_addr;
    end
  end

  assign ram_addr = w_sel_addr;
  assign ram_din  = w_sel_din;
  assign ram_we   = w_sel_we;

  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      r_cpu_rdata <= 4'd0;
      r_cpu_ack   <= 1'b0;
      r_dbg_rdata <= 4'd0;
      r_dbg_ack   <= 1'b0;
      r_last_addr <= 5'd0;
      r_last_din  <= 4'd0;
    end else begin
      r_cpu_ack <= w_gnt_cpu;
      r_dbg_ack <= w_gnt_dbg;
      if (w_gnt_cpu && !cpu_we) begin
        r_cpu_rdata <= ram_dout;
      end
      if (w_gnt_dbg && !dbg_we) begin
        r_dbg_rdata <= ram_dout;
      end
      if (w_any_gnt) begin
        r_last_addr <= w_sel_addr;
        r_last_din  <= w_sel_din;
      end
    end
  end

  // Scanner: a wrap that coincides with a grant re-arms the request without a miss.
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      r_seg_data   <= 4'd0;
      r_seg_digit  <= 5'd0;
      r_seg_valid  <= 1'b0;
      r_scan_miss  <= 1'b0;
      r_scan_pend  <= 1'b0;
      r_period_cnt <= '0;
      r_wait_cnt   <= '0;
      r_scan_idx   <= 5'd0;
    end else begin
      r_seg_valid <= w_gnt_scan;
      if (w_gnt_scan) begin
        r_seg_data  <= ram_dout;
        r_seg_digit <= r_scan_idx;
      end
      if (!scan_en) begin
        r_period_cnt <= '0;
        r_wait_cnt   <= '0;
        r_scan_pend  <= 1'b0;
        r_scan_idx   <= 5'd0;
        r_scan_miss  <= 1'b0;
      end else begin
        r_period_cnt <= w_wrap ? '0 : r_period_cnt + 1'b1;
        if (w_wrap) begin
          r_scan_pend <= 1'b1;
        end else if (w_gnt_scan) begin
          r_scan_pend <= 1'b0;
        end
        if (w_wrap && r_scan_pend && !w_gnt_scan) begin
          r_scan_miss <= 1'b1;
        end
        if (w_gnt_scan) begin
          r_wait_cnt <= '0;
        end else if (r_scan_pend && (r_wait_cnt != WAIT_MAX)) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
        if (w_gnt_scan) begin
          r_scan_idx <= (r_scan_idx == IDX_LAST) ? 5'd0 : r_scan_idx + 5'd1;
        end
      end
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign dbg_rdata = r_dbg_rdata;
  assign dbg_ack   = r_dbg_ack;
  assign seg_data  = r_seg_data;
  assign seg_digit = r_seg_digit;
  assign seg_valid = r_seg_valid;
  assign scan_miss = r_scan_miss;

endmodule

// File: tb/tb_dg0045_ram_arbiter.sv
// tb/tb_dg0045_ram_arbiter.sv - directed self-checking bench for dg0045_ram_arbiter
module tb_dg0045_ram_arbiter;

  logic       clk_in = 1'b0;
  logic       RESET = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [4:0] cpu_addr = 5'd0;
  logic [3:0] cpu_wdata = 4'd0;
  logic       dbg_req = 1'b0, dbg_we = 1'b0;
  logic [4:0] dbg_addr = 5'd0;
  logic [3:0] dbg_wdata = 4'd0;
  logic       scan_en_a = 1'b0, scan_en_b = 1'b0;

  logic [3:0] cpu_rdata_a, dbg_rdata_a, seg_data_a, ram_din_a, ram_dout_a;
  logic       cpu_ack_a, dbg_ack_a, seg_valid_a, scan_miss_a, ram_we_a;
  logic [4:0] seg_digit_a, ram_addr_a;
  logic [3:0] cpu_rdata_b, dbg_rdata_b, seg_data_b, ram_din_b, ram_dout_b;
  logic       cpu_ack_b, dbg_ack_b, seg_valid_b, scan_miss_b, ram_we_b;
  logic [4:0] seg_digit_b, ram_addr_b;

  logic [3:0] mem_a [32];
  logic [3:0] mem_b [32];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) if (ram_we_a) mem_a[ram_addr_a] <= ram_din_a;
  always @(posedge clk_in) if (ram_we_b) mem_b[ram_addr_b] <= ram_din_b;
  assign ram_dout_a = mem_a[ram_addr_a];
  assign ram_dout_b = mem_b[ram_addr_b];

  dg0045_ram_arbiter #(.SCAN_BASE(5'd30), .DIGITS(3), .SCAN_PERIOD(4), .MAX_WAIT(2)) u_dut_a (
    .clk_in(clk_in), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_a), .cpu_ack(cpu_ack_a),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata_a), .dbg_ack(dbg_ack_a),
    .scan_en(scan_en_a), .seg_data(seg_data_a), .seg_digit(seg_digit_a),
    .seg_valid(seg_valid_a), .scan_miss(scan_miss_a),
    .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_we(ram_we_a), .ram_dout(ram_dout_a)
  );

  dg0045_ram_arbiter #(.SCAN_BASE(5'd30), .DIGITS(3), .SCAN_PERIOD(2), .MAX_WAIT(16)) u_dut_b (
    .clk_in(clk_in), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata_b), .dbg_ack(dbg_ack_b),
    .scan_en(scan_en_b), .seg_data(seg_data_b), .seg_digit(seg_digit_b),
    .seg_valid(seg_valid_b), .scan_miss(scan_miss_b),
    .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_we(ram_we_b), .ram_dout(ram_dout_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [3:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    chk("wr_ram_we", 8'(ram_we_a), 8'h1);
    chk("wr_ram_addr", 8'(ram_addr_a), 8'(a));
    tick;
    chk("wr_ack", 8'(cpu_ack_a), 8'h1);
    chk("wr_ram_we_in_ack", 8'(ram_we_a), 8'h0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick;
    chk("wr_ack_low", 8'(cpu_ack_a), 8'h0);
  endtask

  task automatic cpu_read(input logic [4:0] a, input logic [3:0] d);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    chk("rd_ram_we", 8'(ram_we_a), 8'h0);
    chk("rd_ram_addr", 8'(ram_addr_a), 8'(a));
    tick;
    chk("rd_ack", 8'(cpu_ack_a), 8'h1);
    chk("rd_data", 8'(cpu_rdata_a), 8'(d));
    cpu_req = 1'b0;
    tick;
    chk("rd_ack_low", 8'(cpu_ack_a), 8'h0);
    chk("rd_data_hold", 8'(cpu_rdata_a), 8'(d));
  endtask

  task automatic wait_seg_a(output int n);
    n = 0;
    do begin tick; n++; end while (!seg_valid_a && n < 12);
  endtask

  task automatic wait_seg_b(output int n);
    n = 0;
    do begin tick; n++; end while (!seg_valid_b && n < 12);
  endtask

  logic [3:0] exp_dat3 [4] = '{4'h1, 4'h2, 4'h3, 4'h1};
  logic [4:0] exp_dig3 [4] = '{5'd0, 5'd1, 5'd2, 5'd0};
  int         exp_gap3 [4] = '{5, 4, 4, 4};
  int         exp_gap4 [3] = '{7, 4, 4};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    // reset state
    tick; tick;
    chk("rst_cpu_ack", 8'(cpu_ack_a), 8'h0);
    chk("rst_cpu_rdata", 8'(cpu_rdata_a), 8'h0);
    chk("rst_ram_we", 8'(ram_we_a), 8'h0);
    chk("rst_ram_addr", 8'(ram_addr_a), 8'h0);
    chk("rst_seg_valid", 8'(seg_valid_a), 8'h0);
    chk("rst_scan_miss", 8'(scan_miss_a), 8'h0);
    RESET = 1'b1;
    tick;

    // write / read back and preload
    cpu_write(5'h0A, 4'h7);
    cpu_read(5'h0A, 4'h7);
    cpu_write(5'd30, 4'h1);
    cpu_write(5'd31, 4'h2);
    cpu_write(5'd0, 4'h3);
    cpu_write(5'd5, 4'h9);
    cpu_write(5'd6, 4'hC);

    // simultaneous CPU and debug reads
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd6;
    #1;
    chk("both_cpu_wins_addr", 8'(ram_addr_a), 8'h05);
    tick;
    chk("both_cpu_ack", 8'(cpu_ack_a), 8'h1);
    chk("both_cpu_rdata", 8'(cpu_rdata_a), 8'h9);
    chk("both_dbg_not_yet", 8'(dbg_ack_a), 8'h0);
    cpu_req = 1'b0;
    #1;
    chk("both_dbg_addr", 8'(ram_addr_a), 8'h06);
    tick;
    chk("both_dbg_ack", 8'(dbg_ack_a), 8'h1);
    chk("both_dbg_rdata", 8'(dbg_rdata_a), 8'hC);
    chk("both_cpu_ack_low", 8'(cpu_ack_a), 8'h0);
    dbg_req = 1'b0;
    tick;
    chk("both_dbg_ack_low", 8'(dbg_ack_a), 8'h0);

    // uncontested scan with window wrap
    scan_en_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_seg_a(n);
      chk("scan_gap", 8'(n), 8'(exp_gap3[k]));
      chk("scan_data", 8'(seg_data_a), 8'(exp_dat3[k]));
      chk("scan_digit", 8'(seg_digit_a), 8'(exp_dig3[k]));
    end
    tick;
    chk("scan_valid_pulse", 8'(seg_valid_a), 8'h0);
    chk("scan_no_miss", 8'(scan_miss_a), 8'h0);
    scan_en_a = 1'b0;
    tick; tick;

    // starvation guard with CPU and debug saturating
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd5;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd6;
    scan_en_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_seg_a(n);
      chk("guard_gap", 8'(n), 8'(exp_gap4[k]));
      chk("guard_data", 8'(seg_data_a), 8'(exp_dat3[k]));
      chk("guard_digit", 8'(seg_digit_a), 8'(exp_dig3[k]));
    end
    chk("guard_no_miss", 8'(scan_miss_a), 8'h0);
    chk("guard_cpu_rdata", 8'(cpu_rdata_a), 8'h9);
    chk("guard_dbg_rdata", 8'(dbg_rdata_a), 8'hC);
    cpu_req = 1'b0; dbg_req = 1'b0; scan_en_a = 1'b0;
    tick; tick; tick;

    // overrun on the fast-period instance
    cpu_req = 1'b1; dbg_req = 1'b1;
    scan_en_b = 1'b1;
    repeat (6) tick;
    chk("miss_set", 8'(scan_miss_b), 8'h1);
    repeat (30) tick;
    chk("miss_sticky", 8'(scan_miss_b), 8'h1);
    cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (3) tick;
    chk("miss_sticky_idle", 8'(scan_miss_b), 8'h1);
    scan_en_b = 1'b0;
    tick;
    chk("miss_cleared", 8'(scan_miss_b), 8'h0);
    tick; tick;
    scan_en_b = 1'b1;
    wait_seg_b(n);
    chk("restart_gap", 8'(n), 8'h3);
    chk("restart_digit", 8'(seg_digit_b), 8'h0);
    chk("restart_data", 8'(seg_data_b), 8'h1);
    scan_en_b = 1'b0;
    tick; tick;

    // reset during a pending debug read
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd6;
    #2;
    RESET = 1'b0;
    #1;
    chk("rstmid_ram_we", 8'(ram_we_a), 8'h0);
    chk("rstmid_ram_addr", 8'(ram_addr_a), 8'h0);
    tick;
    chk("rstmid_dbg_ack", 8'(dbg_ack_a), 8'h0);
    dbg_req = 1'b0;
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rstpost_dbg_ack", 8'(dbg_ack_a), 8'h0);
    end
    chk("rstpost_cpu_ack", 8'(cpu_ack_a), 8'h0);
    chk("rstpost_cpu_rdata", 8'(cpu_rdata_a), 8'h0);
    chk("rstpost_dbg_rdata", 8'(dbg_rdata_a), 8'h0);
    chk("rstpost_seg_data", 8'(seg_data_a), 8'h0);
    chk("rstpost_seg_digit", 8'(seg_digit_a), 8'h0);
    chk("rstpost_seg_valid", 8'(seg_valid_a), 8'h0);
    chk("rstpost_scan_miss", 8'(scan_miss_a), 8'h0);
    chk("rstpost_ram_addr", 8'(ram_addr_a), 8'h0);
    chk("rstpost_ram_din", 8'(ram_din_a), 8'h0);
    chk("rstpost_ram_we", 8'(ram_we_a), 8'h0);
    chk("rstpost_b_seg_data", 8'(seg_data_b), 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
